usb_rx_linestate: RTL and testbench

Receive-side USB line monitor sitting directly downstream of the board pad control. It consumes the pad-to-device D+/D-/sense signals for one USB port and synchronises, glitch-filters and decodes them into a stable line state. It also detects bus reset (long SE0) and suspend (long idle J), and debounces VBUS sense. One instance is built per USB port; the outputs feed the USB device core.

---
 rtl/usb_rx_linestate_if.sv | 32 +++
 rtl/usb_rx_linestate.sv | 144 ++++++++++++++
 tb/tb_usb_rx_linestate.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/usb_rx_linestate_if.sv
// usb_rx_linestate_if: pad-side inputs and decoded line outputs of one USB port receive monitor.
// Latency: not applicable; this is a signal bundle only.
// Backpressure: none; every signal is a level, sampled on each clock.
//
// slave  : the line monitor (takes pads and controls, drives decoded state)
// master : the environment (pad control plus device core)
interface usb_rx_linestate_if;
  logic       usb_dp_i;       // D+ from pad control, asynchronous
  logic       usb_dn_i;       // D- from pad control, asynchronous
  logic       usb_sense_i;    // VBUS sense from pad control, asynchronous
  logic       tx_active_i;    // device is driving the bus
  logic       rx_enable_i;    // enables reset/suspend detection
  logic [1:0] line_state_o;   // 00 SE0, 01 J, 10 K, 11 SE1
  logic       line_change_o;  // one-cycle pulse on line_state_o update
  logic       dp_o;           // synchronised, unfiltered D+
  logic       dn_o;           // synchronised, unfiltered D-
  logic       usb_reset_o;    // long SE0 seen
  logic       usb_suspend_o;  // long idle J seen
  logic       sense_o;        // debounced VBUS sense

  modport slave (
    input  usb_dp_i, usb_dn_i, usb_sense_i, tx_active_i, rx_enable_i,
    output line_state_o, line_change_o, dp_o, dn_o,
           usb_reset_o, usb_suspend_o, sense_o
  );

  modport master (
    output usb_dp_i, usb_dn_i, usb_sense_i, tx_active_i, rx_enable_i,
    input  line_state_o, line_change_o, dp_o, dn_o,
           usb_reset_o, usb_suspend_o, sense_o
  );
endinterface

// File: rtl/usb_rx_linestate.sv
// usb_rx_linestate: synchronise, glitch-filter and decode USB D+/D-, detect bus reset/suspend, debounce VBUS.
// Latency: pad edge to line_state_o = NumSyncFlops + FilterCycles cycles; sense_o = NumSyncFlops + SenseDebounceCycles.
// Backpressure: none; outputs are levels/pulses consumed every cycle by the device core.
//
// Ports: clk_i, rst_ni (synchronous, active low) plus the slave side of
// usb_rx_linestate_if carrying pads, tx_active/rx_enable and all decoded outputs.
module usb_rx_linestate #(
  parameter int NumSyncFlops        = 2,
  parameter int FilterCycles        = 2,
  parameter int ResetCycles         = 120,
  parameter int SuspendCycles       = 144000,
  parameter int SenseDebounceCycles = 4800
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  usb_rx_linestate_if.slave bus
);

  localparam int FiltW = $clog2(FilterCycles + 1);
  localparam int RstW  = $clog2(ResetCycles + 1);
  localparam int SuspW = $clog2(SuspendCycles + 1);
  localparam int SnsW  = $clog2(SenseDebounceCycles + 1);

  localparam logic [1:0] LS_SE0 = 2'b00;
  localparam logic [1:0] LS_J   = 2'b01;

  // ---------------- synchronisers (MSB is the last stage) ----------------
  logic [NumSyncFlops-1:0] dp_sync, dn_sync, sense_sync;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      dp_sync    <= '1;  // idle J on D+
      dn_sync    <= '0;
      sense_sync <= '0;
    end else begin
      dp_sync    <= {dp_sync[NumSyncFlops-2:0], bus.usb_dp_i};
      dn_sync    <= {dn_sync[NumSyncFlops-2:0], bus.usb_dn_i};
      sense_sync <= {sense_sync[NumSyncFlops-2:0], bus.usb_sense_i};
    end
  end

  logic [1:0] sync_state;
  logic       sense_s;
  assign sync_state = {dn_sync[NumSyncFlops-1], dp_sync[NumSyncFlops-1]};
  assign sense_s    = sense_sync[NumSyncFlops-1];

  // ---------------- line-state filter ----------------
  // filt_cnt holds how many earlier cycles the current differing value has
  // already been stable; filt_run adds the present cycle, so the first cycle
  // a new value appears counts as 1 and the update lands FilterCycles later.
  logic [1:0]       line_q, prev_q;
  logic [FiltW-1:0] filt_cnt, filt_run;
  logic             chg_q, filt_hit;

  always_comb begin
    filt_run = '0;
    if (sync_state != line_q) begin
      if (sync_state == prev_q && filt_cnt != '0) filt_run = filt_cnt + FiltW'(1);
      else                                       filt_run = FiltW'(1);
    end
  end

  assign filt_hit = (filt_run >= FiltW'(FilterCycles));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      line_q   <= LS_J;
      prev_q   <= LS_J;
      filt_cnt <= '0;
      chg_q    <= 1'b0;
    end else begin
      prev_q <= sync_state;
      chg_q  <= 1'b0;
      if (bus.tx_active_i) begin
        filt_cnt <= '0;  // own transmission: hold the decoded state
      end else if (filt_hit) begin
        line_q   <= sync_state;
        chg_q    <= 1'b1;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_run;
      end
    end
  end

  // ---------------- bus reset / suspend detectors ----------------
  logic [RstW-1:0]  se0_cnt;
  logic [SuspW-1:0] idle_cnt;
  logic             detect_off;

  assign detect_off = bus.tx_active_i || !bus.rx_enable_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      se0_cnt  <= '0;
      idle_cnt <= '0;
    end else begin
      if (detect_off || line_q != LS_SE0)          se0_cnt <= '0;
      else if (se0_cnt != RstW'(ResetCycles))      se0_cnt <= se0_cnt + RstW'(1);

      if (detect_off || line_q != LS_J)            idle_cnt <= '0;
      else if (idle_cnt != SuspW'(SuspendCycles))  idle_cnt <= idle_cnt + SuspW'(1);
    end
  end

  // ---------------- VBUS sense debounce ----------------
  // Same run-length scheme as the line filter.
  logic            sense_q, sense_prev;
  logic [SnsW-1:0] sense_cnt, sense_run;

  always_comb begin
    sense_run = '0;
    if (sense_s != sense_q) begin
      if (sense_s == sense_prev && sense_cnt != '0) sense_run = sense_cnt + SnsW'(1);
      else                                         sense_run = SnsW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sense_q    <= 1'b0;
      sense_prev <= 1'b0;
      sense_cnt  <= '0;
    end else begin
      sense_prev <= sense_s;
      if (sense_run >= SnsW'(SenseDebounceCycles)) begin
        sense_q   <= sense_s;
        sense_cnt <= '0;
      end else begin
        sense_cnt <= sense_run;
      end
    end
  end

  // ---------------- outputs ----------------
  assign bus.line_state_o  = line_q;
  assign bus.line_change_o = chg_q;
  assign bus.dp_o          = dp_sync[NumSyncFlops-1];
  assign bus.dn_o          = dn_sync[NumSyncFlops-1];
  assign bus.usb_reset_o   = (se0_cnt == RstW'(ResetCycles));
  assign bus.usb_suspend_o = (idle_cnt == SuspW'(SuspendCycles));
  assign bus.sense_o       = sense_q;

endmodule

// File: tb/tb_usb_rx_linestate.sv
module tb_usb_rx_linestate;

  localparam int SuspCyc = 1440;  // shortened suspend window keeps the run small

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  usb_rx_linestate_if bus ();

  usb_rx_linestate #(
    .NumSyncFlops       (2),
    .FilterCycles       (2),
    .ResetCycles        (120),
    .SuspendCycles      (SuspCyc),
    .SenseDebounceCycles(4800)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus.slave)
  );

  // One record per clock: pads applied before the edge, outputs expected after it.
  typedef struct packed {
    logic       dp;
    logic       dn;
    logic [1:0] line;
    logic       chg;
    logic       dpo;
    logic       dno;
  } vec_t;

  vec_t tbl [24];

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pads(input logic dp, input logic dn);
    bus.usb_dp_i = dp;
    bus.usb_dn_i = dn;
  endtask

  initial begin
    logic seen;
    int   i;

    //            dp    dn    line   chg   dp_o  dn_o
    // 1-cycle SE0 glitch: filtered out
    tbl[0]  = '{1'b0, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0};
    // 2-cycle SE0: passes through, then back to J
    tbl[4]  = '{1'b0, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0};
    // J -> K
    tbl[11] = '{1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1};
    tbl[14] = '{1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1};
    // K -> SE1
    tbl[15] = '{1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1};
    tbl[16] = '{1'b1, 1'b1, 2'b10, 1'b0, 1'b1, 1'b1};
    tbl[17] = '{1'b1, 1'b1, 2'b10, 1'b0, 1'b1, 1'b1};
    tbl[18] = '{1'b1, 1'b1, 2'b11, 1'b1, 1'b1, 1'b1};
    // SE1 -> J
    tbl[19] = '{1'b1, 1'b0, 2'b11, 1'b0, 1'b1, 1'b1};
    tbl[20] = '{1'b1, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0};
    tbl[21] = '{1'b1, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0};
    tbl[22] = '{1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0};
    tbl[23] = '{1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0};

    // ---------------- reset state ----------------
    rst_n           = 1'b0;
    pads(1'b1, 1'b0);
    bus.usb_sense_i = 1'b0;
    bus.tx_active_i = 1'b0;
    bus.rx_enable_i = 1'b1;
    step(2);
    chk("rst_line", {30'd0, bus.line_state_o}, 32'h1);
    chk("rst_flags", {25'd0, bus.line_change_o, bus.dp_o, bus.dn_o, bus.usb_reset_o,
                      bus.usb_suspend_o, bus.sense_o, 1'b0}, 32'h20);

    // ---------------- suspend from idle J ----------------
    rst_n = 1'b1;
    step(SuspCyc - 1);
    chk("susp_early", {31'd0, bus.usb_suspend_o}, 32'h0);
    chk("reset_idle", {31'd0, bus.usb_reset_o}, 32'h0);
    step(1);
    chk("susp_on", {31'd0, bus.usb_suspend_o}, 32'h1);
    pads(1'b0, 1'b1);
    step(4);
    chk("k_line", {30'd0, bus.line_state_o}, 32'h2);
    chk("susp_hold", {31'd0, bus.usb_suspend_o}, 32'h1);
    step(1);
    chk("susp_drop", {31'd0, bus.usb_suspend_o}, 32'h0);
    pads(1'b1, 1'b0);
    step(6);

    // ---------------- filter vectors ----------------
    bus.rx_enable_i = 1'b0;
    for (int v = 0; v < 24; v++) begin
      pads(tbl[v].dp, tbl[v].dn);
      step(1);
      chk($sformatf("vec%0d", v),
          {25'd0, bus.line_state_o, bus.line_change_o, bus.dp_o, bus.dn_o,
           bus.usb_reset_o, bus.usb_suspend_o},
          {25'd0, tbl[v].line, tbl[v].chg, tbl[v].dpo, tbl[v].dno, 2'b00});
    end

    // ---------------- bus reset detect ----------------
    bus.rx_enable_i = 1'b1;
    pads(1'b0, 1'b0);
    step(4);
    chk("se0_latency", {29'd0, bus.line_state_o, bus.line_change_o}, 32'h1);
    step(119);
    chk("reset_early", {31'd0, bus.usb_reset_o}, 32'h0);
    step(1);
    chk("reset_on", {31'd0, bus.usb_reset_o}, 32'h1);
    pads(1'b1, 1'b0);
    step(4);
    chk("reset_hold", {29'd0, bus.line_state_o, bus.usb_reset_o}, 32'h3);
    step(1);
    chk("reset_drop", {31'd0, bus.usb_reset_o}, 32'h0);

    // ---------------- tx_active freeze ----------------
    bus.tx_active_i = 1'b1;
    for (int c = 0; c < 50; c++) begin
      if (c % 2 == 0) pads(1'b0, 1'b1);
      else            pads(1'b1, 1'b0);
      step(1);
      chk($sformatf("tx_frz%0d", c), {29'd0, bus.line_state_o, bus.line_change_o}, 32'h2);
    end
    pads(1'b0, 1'b0);
    seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      step(1);
      seen = seen | bus.usb_reset_o | bus.line_change_o;
    end
    chk("tx_se0_noreset", {31'd0, seen}, 32'h0);
    chk("tx_se0_line", {30'd0, bus.line_state_o}, 32'h1);
    pads(1'b1, 1'b0);
    step(4);
    bus.tx_active_i = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step(1);
      seen = seen | bus.line_change_o;
    end
    chk("tx_release", {29'd0, bus.line_state_o, seen}, 32'h2);

    // ---------------- VBUS sense debounce ----------------
    bus.usb_sense_i = 1'b1; step(50);
    bus.usb_sense_i = 1'b0; step(30);
    bus.usb_sense_i = 1'b1; step(50);
    bus.usb_sense_i = 1'b0; step(40);
    bus.usb_sense_i = 1'b1; step(60);
    bus.usb_sense_i = 1'b0; step(20);
    chk("sense_bounce", {31'd0, bus.sense_o}, 32'h0);
    bus.usb_sense_i = 1'b1;
    step(4801);
    chk("sense_early", {31'd0, bus.sense_o}, 32'h0);
    step(1);
    chk("sense_rise", {31'd0, bus.sense_o}, 32'h1);
    bus.usb_sense_i = 1'b0;
    step(1000);
    chk("sense_dropout", {31'd0, bus.sense_o}, 32'h1);
    bus.usb_sense_i = 1'b1;
    step(10);
    chk("sense_after", {31'd0, bus.sense_o}, 32'h1);

    // ---------------- reset mid-count ----------------
    pads(1'b0, 1'b0);
    step(104);
    chk("se0_cnt100", {29'd0, bus.line_state_o, bus.usb_reset_o}, 32'h0);
    rst_n = 1'b0;
    step(1);
    chk("midrst_state", {28'd0, bus.line_state_o, bus.dp_o, bus.usb_reset_o}, 32'h6);
    rst_n = 1'b1;
    step(123);
    chk("midrst_early", {29'd0, bus.line_state_o, bus.usb_reset_o}, 32'h0);
    step(1);
    chk("midrst_reset", {31'd0, bus.usb_reset_o}, 32'h1);

    // ---------------- rx_enable low ----------------
    bus.rx_enable_i = 1'b0;
    step(1);
    chk("rxen_drop", {31'd0, bus.usb_reset_o}, 32'h0);
    seen = 1'b0;
    for (i = 0; i < 300; i++) begin
      step(1);
      seen = seen | bus.usb_reset_o;
    end
    chk("rxen_noreset", {31'd0, seen}, 32'h0);
    pads(1'b1, 1'b0);
    seen = 1'b0;
    for (i = 0; i < SuspCyc + 100; i++) begin
      step(1);
      seen = seen | bus.usb_suspend_o | bus.usb_reset_o;
    end
    chk("rxen_nosusp", {29'd0, bus.line_state_o, seen}, 32'h2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
